sb_msg_arbiter: RTL

Shares the single 4-bit sideband message channel between the TX-side and RX-side halves of an MBTRAIN substep, such as LINKSPEED. Each requester has a one-deep pending latch. Arbitration between them is round-robin. Each message is sequenced through the sideband busy handshake, and the arbiter returns a per-requester "sent" pulse when the sideband finishes. A watchdog flags a sideband that never accepts or never completes a message.

---
 rtl/sb_msg_arbiter_pkg.sv | 29 ++
 rtl/sb_req_latch.sv | 40 ++++
 rtl/sb_msg_arbiter.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/sb_msg_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// sb_msg_arbiter_pkg: shared states, requester ids and idle message. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package sb_msg_arbiter_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_ISSUE   = 3'd1;
  localparam logic [2:0] ST_WAIT_HI = 3'd2;
  localparam logic [2:0] ST_WAIT_LO = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE    = ST_IDLE,
    S_ISSUE   = ST_ISSUE,
    S_WAIT_HI = ST_WAIT_HI,
    S_WAIT_LO = ST_WAIT_LO,
    S_DONE    = ST_DONE
  } state_t;

  localparam logic REQ_TX = 1'b0;
  localparam logic REQ_RX = 1'b1;

  localparam logic [3:0] MSG_IDLE = 4'b0000;

endpackage

`default_nettype wire

// File: rtl/sb_req_latch.sv
// ---------------------------------------------------------------------------
// sb_req_latch: one-deep pending flag plus message register per requester. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sb_req_latch
  import sb_msg_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       valid,
  input  logic [3:0] msg_in,
  input  logic       clear,
  output logic       pending,
  output logic [3:0] msg
);

  // A strobe landing on the clearing cycle is accepted: the new message wins.
  logic capture;
  assign capture = valid && (!pending || clear);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= 1'b0;
      msg     <= MSG_IDLE;
    end else if (!en) begin
      pending <= 1'b0;
      msg     <= MSG_IDLE;
    end else if (capture) begin
      pending <= 1'b1;
      msg     <= msg_in;
    end else if (clear) begin
      pending <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/sb_msg_arbiter.sv
// ---------------------------------------------------------------------------
// sb_msg_arbiter: round-robin TX/RX sharing of the sideband message channel. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sb_msg_arbiter
  import sb_msg_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 8000,
  parameter int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_en,
  input  logic       i_tx_valid,
  input  logic [3:0] i_tx_message,
  input  logic       i_rx_valid,
  input  logic [3:0] i_rx_message,
  input  logic       i_busy,
  output logic       o_valid,
  output logic [3:0] o_sideband_message,
  output logic       o_tx_sent,
  output logic       o_rx_sent,
  output logic       o_tx_pending,
  output logic       o_rx_pending,
  output logic       o_timeout
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state, state_nx;
  logic             rr_ptr, rr_nx;
  logic             grant, grant_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             timeout_nx;
  logic             busy_q;
  logic             busy_fall;
  logic             active;
  logic             clr_grant;
  logic             tx_clear, rx_clear;
  logic [3:0]       tx_msg, rx_msg;
  logic [1:0]       pend;

  assign busy_fall = busy_q && !i_busy;
  assign pend      = {o_rx_pending, o_tx_pending};

  sb_req_latch u_tx_latch (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (i_en),
    .valid   (i_tx_valid),
    .msg_in  (i_tx_message),
    .clear   (tx_clear),
    .pending (o_tx_pending),
    .msg     (tx_msg)
  );

  sb_req_latch u_rx_latch (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (i_en),
    .valid   (i_rx_valid),
    .msg_in  (i_rx_message),
    .clear   (rx_clear),
    .pending (o_rx_pending),
    .msg     (rx_msg)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      rr_ptr    <= REQ_TX;
      grant     <= REQ_TX;
      cnt       <= '0;
      o_timeout <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state     <= state_nx;
      rr_ptr    <= rr_nx;
      grant     <= grant_nx;
      cnt       <= cnt_nx;
      o_timeout <= timeout_nx;
      busy_q    <= i_busy;
    end
  end

  always_comb begin
    state_nx           = state;
    rr_nx              = rr_ptr;
    grant_nx           = grant;
    cnt_nx             = cnt;
    timeout_nx         = o_timeout;
    clr_grant          = 1'b0;
    active             = 1'b0;
    o_valid            = 1'b0;
    o_tx_sent          = 1'b0;
    o_rx_sent          = 1'b0;
    o_sideband_message = (grant == REQ_TX) ? tx_msg : rx_msg;
    tx_clear           = 1'b0;
    rx_clear           = 1'b0;

    case (state)
      S_IDLE: begin
        o_sideband_message = MSG_IDLE;
        cnt_nx             = '0;
        if (pend[rr_ptr]) begin
          grant_nx = rr_ptr;
          state_nx = S_ISSUE;
        end else if (pend[!rr_ptr]) begin
          grant_nx = !rr_ptr;
          state_nx = S_ISSUE;
        end
      end
      S_ISSUE: begin
        active   = 1'b1;
        o_valid  = 1'b1;
        cnt_nx   = cnt + CNT_W'(1);
        state_nx = S_WAIT_HI;
      end
      S_WAIT_HI: begin
        active = 1'b1;
        cnt_nx = cnt + CNT_W'(1);
        if (i_busy) state_nx = S_WAIT_LO;
      end
      S_WAIT_LO: begin
        active = 1'b1;
        cnt_nx = cnt + CNT_W'(1);
        if (busy_fall) state_nx = S_DONE;
      end
      S_DONE: begin
        o_tx_sent = (grant == REQ_TX);
        o_rx_sent = (grant == REQ_RX);
        clr_grant = 1'b1;
        rr_nx     = !grant;
        state_nx  = S_IDLE;
      end
      default: begin
        o_sideband_message = MSG_IDLE;
        state_nx           = S_IDLE;
      end
    endcase

    // Watchdog expiry overrides any handshake progress on the same edge.
    if (active && (cnt == CNT_LAST)) begin
      timeout_nx = 1'b1;
      clr_grant  = 1'b1;
      state_nx   = S_IDLE;
    end

    if (!i_en) begin
      state_nx   = S_IDLE;
      rr_nx      = REQ_TX;
      timeout_nx = 1'b0;
      cnt_nx     = '0;
      clr_grant  = 1'b0;
    end

    tx_clear = clr_grant && (grant == REQ_TX);
    rx_clear = clr_grant && (grant == REQ_RX);
  end

endmodule

`default_nettype wire
